multicycle_ctrl_fsm: RTL and testbench

//  Multi-cycle sequencer for the MIPS datapath; replaces the single-cycle decoder in the top level.

---
 rtl/multicycle_ctrl_fsm.sv | 258 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: walks each instruction through fetch/decode/execute states,
// drives datapath selects/enables, handshakes with unified memory and counts retired instructions.
module multicycle_ctrl_fsm #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemToReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             AluSrcA,
  output logic [1:0]       AluSrcB,
  output logic [2:0]       AluOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state_o,
  output logic             trap,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11,
    StTrap   = 4'd15
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [1:0] SrcBRt    = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;
  localparam logic [2:0] AluAdd    = 3'b000;
  localparam logic [2:0] AluSub    = 3'b001;
  localparam logic [2:0] AluFunct  = 3'b010;
  localparam logic [1:0] PcAluOut  = 2'b01;
  localparam logic [1:0] PcJump    = 2'b10;

  localparam logic [7:0] WaitMax = 8'(MEM_WAIT_MAX);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl, ctrl_out;
  logic             mem_wait;
  logic             timeout;
  logic             retire;

  // A memory state is stalled whenever the handshake has not completed this cycle.
  assign mem_wait = (state_q == StFetch || state_q == StMemRd || state_q == StMemWr) && !mem_ready;
  assign timeout  = mem_wait && (wait_q == WaitMax);

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SrcBFour;
        ctrl.alu_op    = AluAdd;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = StDecode;
        end else if (timeout) begin
          state_d = StTrap;
        end
      end
      StDecode: begin
        ctrl.alu_src_b = SrcBImmSh;
        ctrl.alu_op    = AluAdd;
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRType:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiEx;
          default:    state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBImm;
        ctrl.alu_op    = AluAdd;
        if (op == OpLw) begin
          state_d = StMemRd;
        end else if (op == OpSw) begin
          state_d = StMemWr;
        end else begin
          state_d = StTrap;
        end
      end
      StMemRd: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (mem_ready) begin
          state_d = StMemWb;
        end else if (timeout) begin
          state_d = StTrap;
        end
      end
      StMemWr: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end else if (timeout) begin
          state_d = StTrap;
        end
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_d         = StFetch;
        retire          = 1'b1;
      end
      StExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBRt;
        ctrl.alu_op    = AluFunct;
        state_d        = StAluWb;
      end
      StAluWb: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        state_d        = StFetch;
        retire         = 1'b1;
      end
      StBranch: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SrcBRt;
        ctrl.alu_op        = AluSub;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PcAluOut;
        state_d            = StFetch;
        retire             = 1'b1;
      end
      StJump: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PcJump;
        state_d        = StFetch;
        retire         = 1'b1;
      end
      StAddiEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBImm;
        ctrl.alu_op    = AluAdd;
        state_d        = StAddiWb;
      end
      StAddiWb: begin
        ctrl.reg_write = 1'b1;
        state_d        = StFetch;
        retire         = 1'b1;
      end
      StTrap: begin
        state_d = StTrap;
      end
      default: begin
        state_d = StTrap;
      end
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = 8'd0;
    end else if (mem_wait) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (retire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      wait_q  <= 8'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset masks the controls combinationally so an in-flight write drops without waiting a clock.
  always_comb begin
    ctrl_out = '0;
    if (rst_n) begin
      ctrl_out = ctrl;
    end
  end

  assign PCWrite     = ctrl_out.pc_write;
  assign PCWriteCond = ctrl_out.pc_write_cond;
  assign IorD        = ctrl_out.iord;
  assign MemRead     = ctrl_out.mem_read;
  assign MemWrite    = ctrl_out.mem_write;
  assign IRWrite     = ctrl_out.ir_write;
  assign MemToReg    = ctrl_out.mem_to_reg;
  assign RegDst      = ctrl_out.reg_dst;
  assign RegWrite    = ctrl_out.reg_write;
  assign AluSrcA     = ctrl_out.alu_src_a;
  assign AluSrcB     = ctrl_out.alu_src_b;
  assign AluOp       = ctrl_out.alu_op;
  assign PCSource    = ctrl_out.pc_source;
  assign state_o     = state_q;
  assign trap        = (state_q == StTrap);
  assign instr_cnt   = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: a per-cycle vector table through every instruction class,
// then hand-written trap, timeout-boundary and mid-instruction reset sequences.
module tb_multicycle_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  op;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemToReg, RegDst, RegWrite, AluSrcA;
  logic [1:0]  AluSrcB, PCSource;
  logic [2:0]  AluOp;
  logic [3:0]  state_o;
  logic        trap;
  logic [31:0] instr_cnt;
  logic [16:0] ctl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.MEM_WAIT_MAX(15), .CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .MemToReg   (MemToReg),
    .RegDst     (RegDst),
    .RegWrite   (RegWrite),
    .AluSrcA    (AluSrcA),
    .AluSrcB    (AluSrcB),
    .AluOp      (AluOp),
    .PCSource   (PCSource),
    .state_o    (state_o),
    .trap       (trap),
    .instr_cnt  (instr_cnt)
  );

  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst,
                RegWrite, AluSrcA, AluSrcB, AluOp, PCSource};

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemToReg,RegDst,RegWrite,AluSrcA,
  //  AluSrcB[1:0],AluOp[2:0],PCSource[1:0]}
  localparam logic [16:0] CZero  = 17'b0_0_0_0_0_0_0_0_0_0_00_000_00;
  localparam logic [16:0] CFetR  = 17'b1_0_0_1_0_1_0_0_0_0_01_000_00;
  localparam logic [16:0] CFetW  = 17'b0_0_0_1_0_0_0_0_0_0_01_000_00;
  localparam logic [16:0] CDec   = 17'b0_0_0_0_0_0_0_0_0_0_11_000_00;
  localparam logic [16:0] CMadr  = 17'b0_0_0_0_0_0_0_0_0_1_10_000_00;
  localparam logic [16:0] CMrd   = 17'b0_0_1_1_0_0_0_0_0_0_00_000_00;
  localparam logic [16:0] CMwb   = 17'b0_0_0_0_0_0_1_0_1_0_00_000_00;
  localparam logic [16:0] CMwr   = 17'b0_0_1_0_1_0_0_0_0_0_00_000_00;
  localparam logic [16:0] CExec  = 17'b0_0_0_0_0_0_0_0_0_1_00_010_00;
  localparam logic [16:0] CAwb   = 17'b0_0_0_0_0_0_0_1_1_0_00_000_00;
  localparam logic [16:0] CBr    = 17'b0_1_0_0_0_0_0_0_0_1_00_001_01;
  localparam logic [16:0] CJmp   = 17'b1_0_0_0_0_0_0_0_0_0_00_000_10;
  localparam logic [16:0] CAiwb  = 17'b0_0_0_0_0_0_0_0_1_0_00_000_00;

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic        trap;
    logic [31:0] cnt;
  } vec_t;

  localparam int NVec = 30;
  vec_t tbl[NVec];

  function automatic vec_t mk(logic r, logic [5:0] o, logic m, logic [3:0] s, logic [16:0] c,
                              logic t, logic [31:0] n);
    vec_t v;
    v.rst_n = r; v.op = o; v.rdy = m; v.st = s; v.ctl = c; v.trap = t; v.cnt = n;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [5:0] o, input logic m);
    @(negedge clk);
    rst_n = r; op = o; mem_ready = m;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 6'h00, 1'b1);
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_ctl", 32'(ctl), 32'(CZero));
    chk("reset_trap", 32'(trap), 32'd0);
    chk("reset_cnt", instr_cnt, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; op = 6'h00; mem_ready = 1'b1;

    tbl[0]  = mk(0, 6'h00, 1, 4'd0,  CZero, 0, 0);
    tbl[1]  = mk(1, 6'h00, 1, 4'd0,  CFetR, 0, 0);
    tbl[2]  = mk(1, 6'h00, 1, 4'd1,  CDec,  0, 0);
    tbl[3]  = mk(1, 6'h00, 1, 4'd6,  CExec, 0, 0);
    tbl[4]  = mk(1, 6'h00, 1, 4'd7,  CAwb,  0, 0);
    tbl[5]  = mk(1, 6'h23, 1, 4'd0,  CFetR, 0, 1);
    tbl[6]  = mk(1, 6'h23, 1, 4'd1,  CDec,  0, 1);
    tbl[7]  = mk(1, 6'h23, 1, 4'd2,  CMadr, 0, 1);
    tbl[8]  = mk(1, 6'h23, 0, 4'd3,  CMrd,  0, 1);
    tbl[9]  = mk(1, 6'h23, 0, 4'd3,  CMrd,  0, 1);
    tbl[10] = mk(1, 6'h23, 0, 4'd3,  CMrd,  0, 1);
    tbl[11] = mk(1, 6'h23, 1, 4'd3,  CMrd,  0, 1);
    tbl[12] = mk(1, 6'h23, 1, 4'd4,  CMwb,  0, 1);
    tbl[13] = mk(1, 6'h2B, 1, 4'd0,  CFetR, 0, 2);
    tbl[14] = mk(1, 6'h2B, 1, 4'd1,  CDec,  0, 2);
    tbl[15] = mk(1, 6'h2B, 1, 4'd2,  CMadr, 0, 2);
    tbl[16] = mk(1, 6'h2B, 1, 4'd5,  CMwr,  0, 2);
    tbl[17] = mk(1, 6'h04, 1, 4'd0,  CFetR, 0, 3);
    tbl[18] = mk(1, 6'h04, 1, 4'd1,  CDec,  0, 3);
    tbl[19] = mk(1, 6'h04, 1, 4'd8,  CBr,   0, 3);
    tbl[20] = mk(1, 6'h02, 1, 4'd0,  CFetR, 0, 4);
    tbl[21] = mk(1, 6'h02, 1, 4'd1,  CDec,  0, 4);
    tbl[22] = mk(1, 6'h02, 1, 4'd9,  CJmp,  0, 4);
    tbl[23] = mk(1, 6'h08, 1, 4'd0,  CFetR, 0, 5);
    tbl[24] = mk(1, 6'h08, 1, 4'd1,  CDec,  0, 5);
    tbl[25] = mk(1, 6'h08, 1, 4'd10, CMadr, 0, 5);
    tbl[26] = mk(1, 6'h08, 1, 4'd11, CAiwb, 0, 5);
    tbl[27] = mk(1, 6'h3F, 1, 4'd0,  CFetR, 0, 6);
    tbl[28] = mk(1, 6'h3F, 1, 4'd1,  CDec,  0, 6);
    tbl[29] = mk(1, 6'h3F, 1, 4'd15, CZero, 1, 6);

    for (int i = 0; i < NVec; i++) begin
      drive(tbl[i].rst_n, tbl[i].op, tbl[i].rdy);
      chk($sformatf("vec%0d_state", i), 32'(state_o), 32'(tbl[i].st));
      chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(tbl[i].ctl));
      chk($sformatf("vec%0d_trap", i), 32'(trap), 32'(tbl[i].trap));
      chk($sformatf("vec%0d_cnt", i), instr_cnt, tbl[i].cnt);
    end

    // Trap is absorbing for 20 cycles regardless of inputs, counter frozen.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, (i % 2 == 0) ? 6'h00 : 6'h23, i[0]);
      chk("trap_hold_state", 32'(state_o), 32'd15);
      chk("trap_hold_ctl", 32'(ctl), 32'(CZero));
      chk("trap_hold_flag", 32'(trap), 32'd1);
      chk("trap_hold_cnt", instr_cnt, 32'd6);
    end
    do_reset();

    // Fetch stalled: 16 waiting cycles (wait count 0..15) then trap.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 6'h00, 1'b0);
      chk("fetch_stall_state", 32'(state_o), 32'd0);
      chk("fetch_stall_irwrite", 32'(IRWrite), 32'd0);
      chk("fetch_stall_ctl", 32'(ctl), 32'(CFetW));
    end
    drive(1'b1, 6'h00, 1'b0);
    chk("fetch_timeout_state", 32'(state_o), 32'd15);
    chk("fetch_timeout_trap", 32'(trap), 32'd1);
    chk("fetch_timeout_irwrite", 32'(IRWrite), 32'd0);
    do_reset();

    // Ready arriving in the final allowed cycle completes without trapping.
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 6'h00, 1'b0);
    end
    drive(1'b1, 6'h00, 1'b1);
    chk("edge_ready_state", 32'(state_o), 32'd0);
    chk("edge_ready_irwrite", 32'(IRWrite), 32'd1);
    drive(1'b1, 6'h00, 1'b1);
    chk("edge_ready_decode", 32'(state_o), 32'd1);
    chk("edge_ready_notrap", 32'(trap), 32'd0);
    do_reset();

    // Retire one R-type, then reset asynchronously while a store is waiting in MEMWR.
    for (int i = 0; i < 4; i++) drive(1'b1, 6'h00, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 6'h2B, 1'b1);
    chk("pre_rst_cnt", instr_cnt, 32'd1);
    drive(1'b1, 6'h2B, 1'b0);
    chk("memwr_state", 32'(state_o), 32'd5);
    chk("memwr_memwrite", 32'(MemWrite), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_memwrite", 32'(MemWrite), 32'd0);
    chk("async_rst_ctl", 32'(ctl), 32'(CZero));
    chk("async_rst_state", 32'(state_o), 32'd0);
    chk("async_rst_cnt", instr_cnt, 32'd0);
    drive(1'b1, 6'h00, 1'b1);
    chk("post_rst_state", 32'(state_o), 32'd0);
    chk("post_rst_cnt", instr_cnt, 32'd0);
    chk("post_rst_ctl", 32'(ctl), 32'(CFetR));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
